// File: rtl/coordinate_display.sv
// coordinate_display
//   Four-digit decimal readout for the VGA overlay. The 12-bit input value is
//   converted to four character codes (thousands first). For each scan
//   coordinate the block reports whether that pixel is a lit pixel of the
//   rendered digits. Glyphs come from a 5x7 font drawn at scale 2.
//
// Ports
//   clk       in   1   VGA pixel clock
//   rst       in   1   asynchronous active-high reset
//   value     in  12   unsigned number to display (0..4095)
//   vga_horz  in  12   current scan column
//   vga_vert  in  12   current scan row
//   digits    out 24   registered character codes {thousands, hundreds, tens, units}
//   pixel_on  out  1   registered flag, 1 when the scan pixel is a lit glyph pixel
module coordinate_display #(
  parameter int ORIGIN_X = 1170,
  parameter int ORIGIN_Y = 64,
  parameter int PITCH    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] value,
  input  logic [11:0] vga_horz,
  input  logic [11:0] vga_vert,
  output logic [23:0] digits,
  output logic        pixel_on
);

  // One glyph is seven 5-bit rows; element [6] is the top row and bit 4 of
  // each row is the leftmost column.
  typedef logic [6:0][4:0] glyph_t;

  localparam logic [12:0] ORG_Y = 13'(ORIGIN_Y);

  logic [23:0] digits_q, digits_d;
  logic        pixel_q, pixel_d;
  logic [15:0] bcd;
  logic [12:0] horzExt, vertExt, cellX;
  logic [2:0]  col, row;
  logic [5:0]  code;
  glyph_t      glyph;
  logic        rowInside;

  // Character ROM: codes 0..25 letters, 26 space, 27 colon, 32..41 digits.
  function automatic glyph_t glyphRom(input logic [5:0] c);
    case (c)
      6'd0:  glyphRom = 35'b01110_10001_10001_11111_10001_10001_10001; // A
      6'd1:  glyphRom = 35'b11110_10001_10001_11110_10001_10001_11110; // B
      6'd2:  glyphRom = 35'b01110_10001_10000_10000_10000_10001_01110; // C
      6'd3:  glyphRom = 35'b11100_10010_10001_10001_10001_10010_11100; // D
      6'd4:  glyphRom = 35'b11111_10000_10000_11110_10000_10000_11111; // E
      6'd5:  glyphRom = 35'b11111_10000_10000_11110_10000_10000_10000; // F
      6'd6:  glyphRom = 35'b01110_10001_10000_10111_10001_10001_01111; // G
      6'd7:  glyphRom = 35'b10001_10001_10001_11111_10001_10001_10001; // H
      6'd8:  glyphRom = 35'b01110_00100_00100_00100_00100_00100_01110; // I
      6'd9:  glyphRom = 35'b00111_00010_00010_00010_00010_10010_01100; // J
      6'd10: glyphRom = 35'b10001_10010_10100_11000_10100_10010_10001; // K
      6'd11: glyphRom = 35'b10000_10000_10000_10000_10000_10000_11111; // L
      6'd12: glyphRom = 35'b10001_11011_10101_10101_10001_10001_10001; // M
      6'd13: glyphRom = 35'b10001_10001_11001_10101_10011_10001_10001; // N
      6'd14: glyphRom = 35'b01110_10001_10001_10001_10001_10001_01110; // O
      6'd15: glyphRom = 35'b11110_10001_10001_11110_10000_10000_10000; // P
      6'd16: glyphRom = 35'b01110_10001_10001_10001_10101_10010_01101; // Q
      6'd17: glyphRom = 35'b11110_10001_10001_11110_10100_10010_10001; // R
      6'd18: glyphRom = 35'b01111_10000_10000_01110_00001_00001_11110; // S
      6'd19: glyphRom = 35'b11111_00100_00100_00100_00100_00100_00100; // T
      6'd20: glyphRom = 35'b10001_10001_10001_10001_10001_10001_01110; // U
      6'd21: glyphRom = 35'b10001_10001_10001_10001_10001_01010_00100; // V
      6'd22: glyphRom = 35'b10001_10001_10001_10101_10101_10101_01010; // W
      6'd23: glyphRom = 35'b10001_10001_01010_00100_01010_10001_10001; // X
      6'd24: glyphRom = 35'b10001_10001_10001_01010_00100_00100_00100; // Y
      6'd25: glyphRom = 35'b11111_00001_00010_00100_01000_10000_11111; // Z
      6'd27: glyphRom = 35'b00000_01100_01100_00000_01100_01100_00000; // :
      6'd32: glyphRom = 35'b01110_10001_10011_10101_11001_10001_01110; // 0
      6'd33: glyphRom = 35'b00100_01100_00100_00100_00100_00100_01110; // 1
      6'd34: glyphRom = 35'b01110_10001_00001_00010_00100_01000_11111; // 2
      6'd35: glyphRom = 35'b11111_00010_00100_00010_00001_10001_01110; // 3
      6'd36: glyphRom = 35'b00010_00110_01010_10010_11111_00010_00010; // 4
      6'd37: glyphRom = 35'b11111_10000_11110_00001_00001_10001_01110; // 5
      6'd38: glyphRom = 35'b00110_01000_10000_11110_10001_10001_01110; // 6
      6'd39: glyphRom = 35'b11111_00001_00010_00100_01000_01000_01000; // 7
      6'd40: glyphRom = 35'b01110_10001_10001_01110_10001_10001_01110; // 8
      6'd41: glyphRom = 35'b01110_10001_10001_01111_00001_00010_01100; // 9
      default: glyphRom = '0; // space and unused codes render blank
    endcase
  endfunction

  // Binary to BCD by double-dabble: before each shift, any nibble of 5 or
  // more gets 3 added so it carries correctly into the next decade.
  always_comb begin
    bcd = '0;
    for (int i = 11; i >= 0; i--) begin
      for (int n = 0; n < 4; n++) begin
        if (bcd[4*n +: 4] >= 4'd5) bcd[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], value[i]};
    end
    // A digit code is 32 + d, i.e. 2'b10 prepended to the BCD nibble.
    digits_d = {2'b10, bcd[15:12], 2'b10, bcd[11:8], 2'b10, bcd[7:4], 2'b10, bcd[3:0]};
  end

  assign horzExt = {1'b0, vga_horz};
  assign vertExt = {1'b0, vga_vert};

  // Cell hit test is done with unsigned bound comparisons before any
  // subtraction, so coordinates left of or above a cell never wrap into it.
  // The cells never overlap, so at most one of them can light the pixel.
  always_comb begin
    pixel_d   = 1'b0;
    cellX     = '0;
    col       = '0;
    code      = '0;
    glyph     = '0;
    rowInside = (vertExt >= ORG_Y) && (vertExt < ORG_Y + 13'd14);
    row       = 3'((vertExt - ORG_Y) >> 1);
    for (int k = 0; k < 4; k++) begin
      cellX = 13'(ORIGIN_X + k * PITCH);
      col   = 3'((horzExt - cellX) >> 1);
      code  = digits_q[6*(3-k) +: 6];
      glyph = glyphRom(code);
      if (rowInside && (horzExt >= cellX) && (horzExt < cellX + 13'd10)) begin
        pixel_d = glyph[3'd6 - row][3'd4 - col];
      end
    end
  end

  // Both outputs are plain one-cycle pipeline registers; reset shows "0000".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= 24'h820820;
      pixel_q  <= 1'b0;
    end else begin
      digits_q <= digits_d;
      pixel_q  <= pixel_d;
    end
  end

  assign digits   = digits_q;
  assign pixel_on = pixel_q;

endmodule

// File: tb/tb_coordinate_display.sv
// tb_coordinate_display
//   Self-checking bench for coordinate_display. A table of
//   {value, coordinate offset, expected pixel} records is applied one at a
//   time; expected results are queued when stimulus is driven and popped when
//   the outputs are sampled. Hand-written sequences cover asynchronous reset
//   and the two-cycle value-to-pixel latency.
module tb_coordinate_display;

  localparam int OX = 1170;
  localparam int OY = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] value;
  logic [11:0] vga_horz;
  logic [11:0] vga_vert;
  logic [23:0] digits;
  logic        pixel_on;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] value;
    int          dx;
    int          dy;
    logic        expPix;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic        expPix;
    logic [23:0] expDigits;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[19];

  coordinate_display #(.ORIGIN_X(OX), .ORIGIN_Y(OY), .PITCH(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .vga_horz (vga_horz),
    .vga_vert (vga_vert),
    .digits   (digits),
    .pixel_on (pixel_on)
  );

  // Free-running pixel clock, period 10.
  always #5 clk = ~clk;

  // Reference conversion of a value to its four character codes.
  function automatic logic [23:0] codesOf(input int v);
    codesOf = {6'(32 + v / 1000), 6'(32 + (v / 100) % 10),
               6'(32 + (v / 10) % 10), 6'(32 + v % 10)};
  endfunction

  task automatic checkPix(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: pixel_on=%b expected %b", name, act, exp);
    end
  endtask

  task automatic checkDig(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: digits=%h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector and queue what the outputs should be once it settles.
  task automatic applyStimulus(input logic [11:0] v, input int dx, input int dy,
                               input logic expPix, input string name);
    exp_t e;
    value    = v;
    vga_horz = 12'(OX + dx);
    vga_vert = 12'(OY + dy);
    e.name      = name;
    e.expPix    = expPix;
    e.expDigits = codesOf(int'(v));
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it to the current outputs.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: queue empty when output sampled");
    end else begin
      e = sb.pop_front();
      checkPix(e.name, pixel_on, e.expPix);
      checkDig({e.name, "_digits"}, digits, e.expDigits);
    end
  endtask

  initial begin
    vecs = '{
      '{12'd1111,  4,  0, 1'b1, "g1_r0c2"},
      '{12'd1111,  0,  0, 1'b0, "g1_r0c0"},
      '{12'd1111,  2,  2, 1'b1, "g1_r1c1"},
      '{12'd1111, 19, 13, 1'b1, "g1_cell1_r6c2"},
      '{12'd0,    12,  4, 1'b0, "gap_cell0_cell1"},
      '{12'd0,    -1,  4, 1'b0, "left_of_origin"},
      '{12'd0,     2, 14, 1'b0, "below_cell"},
      '{12'd0,     4, -1, 1'b0, "above_cell"},
      '{12'd0,     2,  2, 1'b0, "g0_r1c1"},
      '{12'd0,     0,  2, 1'b1, "g0_r1c0"},
      '{12'd0,     9,  2, 1'b1, "g0_r1c4_right_edge"},
      '{12'd0,    10,  2, 1'b0, "g0_past_right_edge"},
      '{12'd640,  15,  6, 1'b1, "g6_r3c0"},
      '{12'd4095, 45,  0, 1'b1, "g5_r0c0"},
      '{12'd4095, 38,  6, 1'b1, "g9_r3c4"},
      '{12'd4095, 54,  0, 1'b1, "g5_r0c4"},
      '{12'd4095, 55,  0, 1'b0, "past_last_cell"},
      '{12'd7,    53,  0, 1'b1, "g7_r0c4"},
      '{12'd7,    30, 12, 1'b0, "g0_r6c0_tens"}
    };

    rst      = 1'b0;
    value    = 12'd0;
    vga_horz = 12'd0;
    vga_vert = 12'd0;

    // Asynchronous reset before any clock edge has occurred.
    #3 rst = 1'b1;
    #1;
    checkDig("reset_digits", digits, 24'h820820);
    checkPix("reset_pixel", pixel_on, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Conversion spot checks against fixed codes.
    @(negedge clk);
    value = 12'd640;
    @(posedge clk);
    @(negedge clk);
    checkDig("conv_640", digits, 24'h826920);
    value = 12'd4095;
    @(posedge clk);
    @(negedge clk);
    checkDig("conv_4095", digits, {6'd36, 6'd32, 6'd41, 6'd37});

    // Table-driven vectors; each is held two edges so digits and pixel settle.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].value, vecs[i].dx, vecs[i].dy, vecs[i].expPix, vecs[i].name);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
    end

    // Latency: value 0 -> 1000 at (OX, OY+2); '0' row1 col0 lit, '1' dark.
    @(negedge clk);
    applyStimulus(12'd0, 0, 2, 1'b1, "lat_settle");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
    value = 12'd1000;
    @(posedge clk);
    @(negedge clk);
    checkPix("lat_edge1_pixel", pixel_on, 1'b1);
    checkDig("lat_edge1_digits", digits, codesOf(1000));
    @(posedge clk);
    @(negedge clk);
    checkPix("lat_edge2_pixel", pixel_on, 1'b0);

    // Same change at (OX+4, OY): row0 col2 is lit in both '0' and '1'.
    applyStimulus(12'd0, 4, 0, 1'b1, "lat2_settle");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
    value = 12'd1000;
    @(posedge clk);
    @(negedge clk);
    checkPix("lat2_edge1_pixel", pixel_on, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkPix("lat2_edge2_pixel", pixel_on, 1'b1);

    // Mid-frame reset while showing 1000 at (OX, OY+2).
    vga_horz = 12'(OX);
    vga_vert = 12'(OY + 2);
    @(posedge clk);
    @(negedge clk);
    checkPix("pre_reset_pixel", pixel_on, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkDig("midreset_digits", digits, 24'h820820);
    checkPix("midreset_pixel", pixel_on, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // First edge after release: digits resample 1000, pixel renders "0000".
    @(posedge clk);
    @(negedge clk);
    checkDig("post_reset_digits", digits, codesOf(1000));
    checkPix("post_reset_pixel_from_0000", pixel_on, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkPix("post_reset_pixel_from_1000", pixel_on, 1'b0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
